// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared FSM states, byte-lane geometry and address checks for the memory responder
package rv_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam int LANES       = 4;
    localparam int LANE_W      = 8;
    localparam int LATENCY_MIN = 1;

    // Unsigned 32-bit compare; a wrapped subtraction lands above depth and is rejected.
    function automatic logic addr_bad(input logic [31:0] a, input logic [31:0] base, input logic [31:0] depth);
        return (a[1:0] != 2'b00) || (a < base) || (((a - base) >> 2) >= depth);
    endfunction

endpackage

// File: rtl/rv_mem_array.sv
// rv_mem_array: single-port word RAM with per-byte write enables and a registered read port
module rv_mem_array
    import rv_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [IW-1:0]           i_idx,
    input  logic [LANES-1:0]        i_be,
    input  logic [LANES*LANE_W-1:0] i_wdata,
    output logic [LANES*LANE_W-1:0] o_rdata
);

    logic [LANES*LANE_W-1:0] r_mem [DEPTH];
    logic [LANES*LANE_W-1:0] r_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++)
            if (i_we && i_be[b])
                r_mem[i_idx][b*LANE_W +: LANE_W] <= i_wdata[b*LANE_W +: LANE_W];
        if (i_re)
            r_q <= r_mem[i_idx];
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/rv_mem_resp.sv
// rv_mem_resp: fixed-latency word memory responder for the multicycle core's fetch and load/store port
module rv_mem_resp
    import rv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [LANES-1:0] wstrb,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic             err
);

    localparam int   IW   = $clog2(DEPTH_WORDS);
    localparam int   CW   = $clog2(LATENCY + 1);
    localparam logic LAT1 = (LATENCY == 1);

    if (LATENCY < LATENCY_MIN) begin : g_lat_chk
        $error("rv_mem_resp: LATENCY must be at least %0d", LATENCY_MIN);
    end
    if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_chk
        $error("rv_mem_resp: DEPTH_WORDS must be a power of two");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_base_chk
        $error("rv_mem_resp: BASE_ADDR must be word-aligned");
    end

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_ready;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [LANES-1:0] r_wstrb;

    logic             w_bad;
    logic             w_to_resp;
    logic             w_ram_we;
    logic [31:0]      w_ram_addr;
    logic [IW-1:0]    w_idx;
    logic [31:0]      w_ram_q;

    assign w_bad      = addr_bad(r_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    // The RAM read is launched the cycle before RESP; with LATENCY=1 that is the accepting cycle itself.
    assign w_to_resp  = (r_state == IDLE) ? (req && LAT1) : ((r_state == BUSY) && (r_cnt == CW'(1)));
    assign w_ram_addr = (r_state == IDLE) ? addr : r_addr;
    assign w_idx      = IW'((w_ram_addr - BASE_ADDR) >> 2);
    assign w_ram_we   = r_ready && r_we && !w_bad && !rst;

    rv_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_to_resp),
        .i_idx   (w_idx),
        .i_be    (r_wstrb),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            case (r_state)
                IDLE: if (req) begin
                    r_we    <= we;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    r_wstrb <= wstrb;
                    r_cnt   <= CW'(LATENCY - 1);
                    r_state <= LAT1 ? RESP : BUSY;
                    r_ready <= LAT1;
                end
                BUSY: begin
                    r_cnt   <= r_cnt - CW'(1);
                    r_state <= (r_cnt == CW'(1)) ? RESP : BUSY;
                    r_ready <= (r_cnt == CW'(1));
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign err   = r_ready && w_bad;
    assign rdata = (r_ready && !r_we && !w_bad) ? w_ram_q : '0;

endmodule
